uart_attack_tx: RTL and testbench

UART_ATTACK_TX -- requirements
Module: uart_attack_tx

---
 rtl/battleship_pkg.sv | 28 ++
 rtl/baud_gen.sv | 50 +++++
 rtl/uart_attack_tx.sv | 169 ++++++++++++++++
 tb/tb_uart_attack_tx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/battleship_pkg.sv
`default_nettype none
// ============================================================================
// Module      : battleship_pkg
// Description : Shared definitions for the battleship UART attack transmitter:
//               transmitter state encoding and frame layout constants.
// Revision    : 1.0 - initial release
// ============================================================================
package battleship_pkg;

  // Transmitter states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Every frame opens with this header byte.
  localparam logic [7:0] FRAME_HDR = 8'hA5;

  // Header plus the two payload bytes.
  localparam int FRAME_BYTES = 3;

  // Index of the final byte in a frame, sized for the 2-bit byte counter.
  localparam logic [1:0] LAST_BYTE_IDX = 2'(FRAME_BYTES - 1);

endpackage
`default_nettype wire

// File: rtl/baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : baud_gen
// Description : Bit-time counter. Emits a one-cycle tick in the last cycle of
//               each bit period. Holding restart high keeps the count at zero,
//               so the first bit after restart is a full bit long.
// Revision    : 1.0 - initial release
//
// Ports
//   clk     in   system clock
//   clr_n   in   asynchronous active-low reset
//   restart in   force the counter to zero on the next edge
//   tick    out  high during the final cycle of a bit period
// ============================================================================
module baud_gen #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic clr_n,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = !restart && (cnt_q == LAST);

  // Wrapping at LAST coincides with every state change of the transmitter,
  // which is what reloads the bit timer at each boundary.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_attack_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_attack_tx
// Description : Sends a 16-bit attack vector as a 3-byte UART frame
//               (0xA5, data[7:0], data[15:8]), 8N1, LSB first.
//               A rising edge on send starts a frame; edges seen while a
//               frame is in flight are dropped.
// Revision    : 1.0 - initial release
//
// Ports
//   clk    in   system clock
//   clr_n  in   asynchronous active-low reset
//   data   in   16-bit attack vector, sampled when a frame is accepted
//   send   in   level request; a rising edge starts one frame
//   tx     out  serial line, idle high, registered
//   busy   out  high while a frame is in progress
//   done   out  one-cycle pulse after the final stop bit
// ============================================================================
module uart_attack_tx #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 9600
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [15:0] data,
  input  logic        send,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  import battleship_pkg::*;

  // Must come out at 2 or more for the bit timer to work.
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

  tx_state_t   state_q,    state_d;
  logic [15:0] hold_q,     hold_d;
  logic [7:0]  shreg_q,    shreg_d;
  logic [2:0]  bit_idx_q,  bit_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic        tx_q,       tx_d;
  logic        busy_q,     busy_d;
  logic        done_q,     done_d;
  logic        send_q;
  logic        arm_q,      arm_d;
  logic        send_rise;
  logic        tick;

  // Bit timer is held at zero while idle so the start bit gets a full period.
  baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .clk     (clk),
    .clr_n   (clr_n),
    .restart (state_q == ST_IDLE),
    .tick    (tick)
  );

  // arm_q stays low after reset until send has been seen low, so a request
  // already high when reset lifts is not mistaken for a fresh edge.
  assign arm_d     = arm_q | ~send;
  assign send_rise = send & ~send_q & arm_q;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    tx_d       = tx_q;
    done_d     = 1'b0;

    // tx_d always reflects the bit of the state being entered, so the
    // registered line changes exactly at the bit boundary.
    case (state_q)
      ST_IDLE: begin
        tx_d       = 1'b1;
        bit_idx_d  = 3'd0;
        byte_idx_d = 2'd0;
        if (send_rise) begin
          state_d = ST_START;
          hold_d  = data;
          shreg_d = FRAME_HDR;
          tx_d    = 1'b0;
        end
      end

      ST_START: begin
        if (tick) begin
          state_d   = ST_DATA;
          tx_d      = shreg_q[0];
          shreg_d   = {1'b0, shreg_q[7:1]};
          bit_idx_d = 3'd0;
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (bit_idx_q == 3'd7) begin
            state_d   = ST_STOP;
            tx_d      = 1'b1;
            bit_idx_d = 3'd0;
          end else begin
            tx_d      = shreg_q[0];
            shreg_d   = {1'b0, shreg_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      ST_STOP: begin
        if (tick) begin
          if (byte_idx_q < LAST_BYTE_IDX) begin
            state_d    = ST_START;
            tx_d       = 1'b0;
            byte_idx_d = byte_idx_q + 2'd1;
            shreg_d    = (byte_idx_q == 2'd0) ? hold_q[7:0] : hold_q[15:8];
          end else begin
            state_d    = ST_IDLE;
            tx_d       = 1'b1;
            byte_idx_d = 2'd0;
            done_d     = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Falls together with the done pulse, rises with the start bit.
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      shreg_q    <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      send_q     <= 1'b0;
      arm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      shreg_q    <= shreg_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      send_q     <= send;
      arm_q      <= arm_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_attack_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_attack_tx
// Description : Self-checking bench for uart_attack_tx. The expected line is
//               derived from the frame's byte list with plain arithmetic and
//               compared cycle by cycle; bytes are also decoded mid-bit.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_attack_tx;

  localparam int CLK_HZ    = 1000000;
  localparam int BAUD      = 100000;
  localparam int CPB       = CLK_HZ / BAUD;
  localparam int FRAME_CYC = 30 * CPB;

  logic        clk   = 1'b0;
  logic        clr_n = 1'b0;
  logic        send  = 1'b0;
  logic [15:0] data  = 16'h0000;
  logic        tx;
  logic        busy;
  logic        done;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [15:0] d;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
  } vec_t;

  vec_t tbl [4];

  uart_attack_tx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .data  (data),
    .send  (send),
    .tx    (tx),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected line level k cycles after the start bit begins.
  // bytes = {byte2, byte1, byte0}; each byte is 10 bits: 0, d0..d7, 1.
  function automatic logic exp_line(input logic [23:0] bytes, input int k);
    int bp, byt, w;
    bp  = k / CPB;
    byt = bp / 10;
    w   = bp % 10;
    if (w == 0) return 1'b0;
    if (w == 9) return 1'b1;
    return bytes[byt*8 + w - 1];
  endfunction

  // Release send, then raise it with new data; returns just after the
  // accepting edge.
  task automatic launch(input logic [15:0] d);
    send = 1'b0;
    step();
    data = d;
    send = 1'b1;
    step();
  endtask

  // Called just after the accepting edge. mode: 0 drop send early,
  // 1 also change data mid-frame, 2 toggle send and leave it high.
  // abort_at >= 0 pulls clr_n low at that cycle offset.
  task automatic check_frame(input logic [23:0] expb, input string nm,
                             input int mode, input int abort_at);
    logic [7:0] dec [3];
    int tx_err   = 0;
    int busy_err = 0;
    int done_err = 0;
    bit aborted  = 1'b0;
    for (int k = 0; k < FRAME_CYC; k++) begin
      if (tx !== exp_line(expb, k)) tx_err++;
      if (busy !== 1'b1) busy_err++;
      if (done !== 1'b0) done_err++;
      if ((k % CPB) == CPB / 2) begin
        int bp;
        bp = k / CPB;
        if ((bp % 10) >= 1 && (bp % 10) <= 8) dec[bp/10][(bp%10)-1] = tx;
      end
      if (mode != 2 && k == 2) send = 1'b0;
      if (mode == 1 && k == 0) data = 16'hFFFF;
      if (mode == 2) begin
        case (k)
          40, 80, 120: send = 1'b0;
          60, 100, 140: send = 1'b1;
          default: ;
        endcase
      end
      if (k == abort_at) begin
        clr_n = 1'b0;
        #1;
        chk({nm, " abort tx"}, 32'(tx), 32'd1);
        chk({nm, " abort busy"}, 32'(busy), 32'd0);
        chk({nm, " abort done"}, 32'(done), 32'd0);
        aborted = 1'b1;
        break;
      end
      step();
    end
    chk({nm, " tx waveform errs"}, tx_err, 0);
    chk({nm, " busy errs"}, busy_err, 0);
    chk({nm, " early done errs"}, done_err, 0);
    if (!aborted) begin
      chk({nm, " byte0"}, 32'(dec[0]), 32'(expb[7:0]));
      chk({nm, " byte1"}, 32'(dec[1]), 32'(expb[15:8]));
      chk({nm, " byte2"}, 32'(dec[2]), 32'(expb[23:16]));
      chk({nm, " done at 30 bits"}, 32'(done), 32'd1);
      chk({nm, " busy low with done"}, 32'(busy), 32'd0);
      chk({nm, " tx idle with done"}, 32'(tx), 32'd1);
    end
  endtask

  initial begin
    int errs;
    logic [15:0] rd;

    tbl[0] = '{16'h8001, 8'hA5, 8'h01, 8'h80};
    tbl[1] = '{16'h0000, 8'hA5, 8'h00, 8'h00};
    tbl[2] = '{16'hFFFF, 8'hA5, 8'hFF, 8'hFF};
    tbl[3] = '{16'h5AC3, 8'hA5, 8'hC3, 8'h5A};

    // Reset state
    clr_n = 1'b0;
    repeat (3) step();
    chk("reset tx", 32'(tx), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    clr_n = 1'b1;

    // Idle 50 cycles
    errs = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) errs++;
    end
    chk("idle 50 errs", errs, 0);

    // Table-driven frames
    for (int i = 0; i < 4; i++) begin
      launch(tbl[i].d);
      check_frame({tbl[i].b2, tbl[i].b1, tbl[i].b0}, $sformatf("tbl%0d", i), 0, -1);
      step();
      chk($sformatf("tbl%0d done one cycle", i), 32'(done), 32'd0);
    end

    // Data changed after acceptance does not affect the frame
    launch(16'h8001);
    check_frame({8'h80, 8'h01, 8'hA5}, "late data", 1, -1);

    // Edges while busy dropped; send held high gives one frame
    launch(16'h3C5A);
    check_frame({8'h3C, 8'h5A, 8'hA5}, "toggle", 2, -1);
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) errs++;
    end
    chk("held send single frame errs", errs, 0);
    send = 1'b0;

    // Reset during byte 1, bit 4
    launch(16'h8001);
    check_frame({8'h80, 8'h01, 8'hA5}, "abort", 0, 15 * CPB + 3);
    step();
    chk("in reset tx", 32'(tx), 32'd1);
    chk("in reset done", 32'(done), 32'd0);
    clr_n = 1'b1;
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done !== 1'b0 || tx !== 1'b1) errs++;
    end
    chk("post abort quiet errs", errs, 0);
    launch(16'hBEEF);
    check_frame({8'hBE, 8'hEF, 8'hA5}, "after abort", 0, -1);

    // Back-to-back: new edge in the done cycle
    launch(16'h4321);
    check_frame({8'h43, 8'h21, 8'hA5}, "b2b first", 0, -1);
    data = 16'h1234;
    send = 1'b1;
    step();
    check_frame({8'h12, 8'h34, 8'hA5}, "b2b second", 0, -1);

    // send already high when reset lifts
    send  = 1'b1;
    clr_n = 1'b0;
    step();
    clr_n = 1'b1;
    errs = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0) errs++;
    end
    chk("send high through reset errs", errs, 0);
    launch(16'hCAFE);
    check_frame({8'hCA, 8'hFE, 8'hA5}, "rearm", 0, -1);

    // Randomized frames
    for (int i = 0; i < 4; i++) begin
      rd = 16'($urandom);
      launch(rd);
      check_frame({rd[15:8], rd[7:0], 8'hA5}, $sformatf("rand%0d %04h", i, rd), 0, -1);
    end

    repeat (5) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
